// File: rtl/decoder_scan_seq.sv
// Select-index sequencer feeding the 3-to-8 one-hot decoder stage.
// Optional SCAN_BLANK_EN inserts a one-cycle blank before each index advance.
module decoder_scan_seq #(
   parameter int SEL_W   = 3,
   parameter int DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic               single,
   input  logic [DWELL_W-1:0] dwell,
   input  logic [SEL_W-1:0]   last,
   output logic [SEL_W-1:0]   sel,
   output logic               sel_valid,
   output logic               busy,
   output logic               step,
   output logic               done
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] BLANK = 2'd2;

   logic [1:0]         state;
   logic [DWELL_W-1:0] cnt;
   logic [DWELL_W-1:0] dwell_q;
   logic [SEL_W-1:0]   last_q;
   logic               single_q;
   logic [SEL_W-1:0]   sel_nxt;

   // Wrap back to 0 after the latched final index.
   assign sel_nxt = (sel == last_q) ? '0 : sel + SEL_W'(1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         dwell_q   <= '0;
         last_q    <= '0;
         single_q  <= 1'b0;
         sel       <= '0;
         sel_valid <= 1'b0;
         busy      <= 1'b0;
         step      <= 1'b0;
         done      <= 1'b0;
      end else begin
         step <= 1'b0;
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !stop) begin
                  dwell_q   <= dwell;
                  last_q    <= last;
                  single_q  <= single;
                  state     <= RUN;
                  cnt       <= '0;
                  sel       <= '0;
                  sel_valid <= 1'b1;
                  busy      <= 1'b1;
               end
            end
            RUN: begin
               if (stop) begin
                  state     <= IDLE;
                  cnt       <= '0;
                  sel       <= '0;
                  sel_valid <= 1'b0;
                  busy      <= 1'b0;
               end else if (cnt == dwell_q) begin
                  cnt <= '0;
                  if (single_q && (sel == last_q)) begin
                     state     <= IDLE;
                     sel       <= '0;
                     sel_valid <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                  end else begin
`ifdef SCAN_BLANK_EN
                     state     <= BLANK;
                     sel_valid <= 1'b0;
`else
                     sel  <= sel_nxt;
                     step <= 1'b1;
`endif
                  end
               end else begin
                  cnt <= cnt + DWELL_W'(1);
               end
            end
`ifdef SCAN_BLANK_EN
            BLANK: begin
               if (stop) begin
                  state <= IDLE;
                  sel   <= '0;
                  busy  <= 1'b0;
               end else begin
                  state     <= RUN;
                  sel       <= sel_nxt;
                  sel_valid <= 1'b1;
                  step      <= 1'b1;
               end
            end
`endif
            default: begin
               state     <= IDLE;
               cnt       <= '0;
               sel       <= '0;
               sel_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_decoder_scan_seq.sv
// Directed bench for decoder_scan_seq; SCAN_BLANK_EN selects the blank-mode vectors.
module tb_decoder_scan_seq;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       stop;
   logic       single;
   logic [7:0] dwell;
   logic [2:0] last;
   logic [2:0] sel;
   logic       sel_valid;
   logic       busy;
   logic       step;
   logic       done;

   int checks = 0;
   int errors = 0;

   decoder_scan_seq #(.SEL_W(3), .DWELL_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .stop      (stop),
      .single    (single),
      .dwell     (dwell),
      .last      (last),
      .sel       (sel),
      .sel_valid (sel_valid),
      .busy      (busy),
      .step      (step),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic chk_idle(input string tag);
      check({tag, "_sel"}, 32'(sel), 0);
      check({tag, "_vld"}, 32'(sel_valid), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_step"}, 32'(step), 0);
   endtask

`ifdef SCAN_BLANK_EN
   int b_sel[8]  = '{0, 0, 0, 1, 1, 1, 2, 2};
   int b_vld[8]  = '{1, 1, 0, 1, 1, 0, 1, 1};
   int b_step[8] = '{0, 0, 0, 1, 0, 0, 1, 0};
`else
   int s_sel[12] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3};
   int s_stp[12] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0};
`endif

   initial begin
      rst_n  = 1'b0;
      start  = 1'b1;
      stop   = 1'b0;
      single = 1'b0;
      dwell  = 8'd0;
      last   = 3'd0;
      cyc();
      cyc();
      chk_idle("rst");
      check("rst_done", 32'(done), 0);
      rst_n = 1'b1;
      start = 1'b0;
      cyc();
      cyc();
      chk_idle("rel");

`ifdef SCAN_BLANK_EN
      dwell  = 8'd1;
      last   = 3'd2;
      single = 1'b1;
      start  = 1'b1;
      cyc();
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("blk_sel%0d", i), 32'(sel), 32'(b_sel[i]));
         check($sformatf("blk_vld%0d", i), 32'(sel_valid), 32'(b_vld[i]));
         check($sformatf("blk_stp%0d", i), 32'(step), 32'(b_step[i]));
         check($sformatf("blk_dn%0d", i), 32'(done), 0);
         cyc();
      end
      check("blk_done", 32'(done), 1);
      chk_idle("blk_end");
      cyc();
      check("blk_done_clr", 32'(done), 0);
`else
      // single sweep, dwell 2, last 3
      dwell  = 8'd2;
      last   = 3'd3;
      single = 1'b1;
      start  = 1'b1;
      cyc();
      start = 1'b0;
      for (int i = 0; i < 12; i++) begin
         check($sformatf("sw_sel%0d", i), 32'(sel), 32'(s_sel[i]));
         check($sformatf("sw_vld%0d", i), 32'(sel_valid), 1);
         check($sformatf("sw_busy%0d", i), 32'(busy), 1);
         check($sformatf("sw_stp%0d", i), 32'(step), 32'(s_stp[i]));
         check($sformatf("sw_dn%0d", i), 32'(done), 0);
         cyc();
      end
      check("sw_done", 32'(done), 1);
      chk_idle("sw_end");
      cyc();
      check("sw_done_clr", 32'(done), 0);

      // continuous wrap, dwell 0, last 7
      dwell  = 8'd0;
      last   = 3'd7;
      single = 1'b0;
      start  = 1'b1;
      cyc();
      start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         check($sformatf("wr_sel%0d", i), 32'(sel), 32'(i % 8));
         check($sformatf("wr_stp%0d", i), 32'(step), (i > 0) ? 1 : 0);
         check($sformatf("wr_dn%0d", i), 32'(done), 0);
         cyc();
      end
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      chk_idle("wr_stop");

      // stop mid-scan at sel 2
      dwell = 8'd3;
      last  = 3'd5;
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int i = 0; i < 8; i++) cyc();
      check("st_sel2", 32'(sel), 2);
      check("st_busy", 32'(busy), 1);
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      chk_idle("st_abort");
      check("st_done", 32'(done), 0);
      start = 1'b1;
      stop  = 1'b1;
      cyc();
      check("st_both_busy", 32'(busy), 0);
      check("st_both_vld", 32'(sel_valid), 0);
      start = 1'b0;
      stop  = 1'b0;

      // latching and restart in the done cycle
      dwell  = 8'd0;
      last   = 3'd3;
      single = 1'b1;
      start  = 1'b1;
      cyc();
      start  = 1'b0;
      last   = 3'd1;
      dwell  = 8'd5;
      single = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("lt_sel%0d", i), 32'(sel), 32'(i));
         check($sformatf("lt_busy%0d", i), 32'(busy), 1);
         cyc();
      end
      check("lt_done", 32'(done), 1);
      check("lt_busy_end", 32'(busy), 0);
      start = 1'b1;
      cyc();
      start = 1'b0;
      check("rs_busy", 32'(busy), 1);
      check("rs_sel", 32'(sel), 0);
      check("rs_vld", 32'(sel_valid), 1);
      check("rs_done", 32'(done), 0);
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      chk_idle("rs_stop");
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/decoder_scan_seq.md
Name: decoder_scan_seq

Overview:
Upstream sequencer for the 3-to-8 one-hot decoder stage. It generates the decoder's select index, stepping 0..last with a programmable dwell per index. It supports continuous or single-sweep operation and provides start/stop control plus status and step/done pulses. It sits between the control logic and the decoder. sel drives the decoder input directly, and sel_valid gates the decoder's consumer.

Parameters:
SEL_W, 3, select width; must match the decoder input width.
DWELL_W, 8, dwell counter width.

Ports:
clk  input  1  rising-edge clock, single clock domain
rst_n  input  1  synchronous active-low reset
start  input  1  level sampled each cycle; begins a scan when IDLE
stop  input  1  aborts the scan; takes priority over start
single  input  1  1 = one sweep then stop; 0 = continuous; latched at start
dwell  input  DWELL_W  hold cycles minus 1 per index; latched at start
last  input  SEL_W  final index of the sweep; latched at start
sel  output  SEL_W  registered select index to the decoder
sel_valid  output  1  sel is an active scan index
busy  output  1  scan in progress
step  output  1  one-cycle pulse on the cycle sel takes a new value (excluding first entry)
done  output  1  one-cycle pulse at completion of a single sweep

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (clk, rst_n). While rst_n=0 at a clk edge: state=IDLE, sel=0, sel_valid=0, busy=0, step=0, done=0, dwell counter=0. Reset mid-scan aborts immediately with no done pulse.
- All outputs are registered. No combinational input-to-output paths.
- States: IDLE, RUN (plus BLANK, see Optional Feature).
- IDLE:
  - start=1 and stop=0 at edge N: latch dwell, last, single; enter RUN.
  - After edge N: sel=0, sel_valid=1, busy=1, step=0, dwell counter=0.
  - start=1 and stop=1 together: remain IDLE.
- RUN:
  - Each index is held for dwell+1 cycles. dwell=0 gives a new index every cycle.
  - The counter increments each cycle. When it equals the latched dwell, the counter clears and the index advances.
  - Advance with sel<last: sel<=sel+1, step=1 for one cycle.
  - Advance with sel==last, continuous mode: sel<=0 (wrap), step=1.
  - Advance with sel==last, single mode: go to IDLE; sel=0, sel_valid=0, busy=0, done=1 for one cycle, step=0.
  - last=0: index 0 only. In continuous mode a step pulse occurs every dwell+1 cycles with sel staying 0.
  - last=7 with SEL_W=3: wrap 7->0 via modulo arithmetic, no overflow.
  - start while RUN: ignored. Changes to dwell, last or single during RUN: no effect until the next start.
- stop=1 in RUN (or BLANK) at an edge: go to IDLE. sel=0, sel_valid=0, busy=0, no done, no step. stop has priority over a simultaneous advance.
- done and start: done is asserted in IDLE. A start sampled in that same cycle starts a new scan on the next edge.

Optional Feature:
Macro SCAN_BLANK_EN.
- Defined: a one-cycle BLANK state is inserted before every index advance, including the wrap. During BLANK, sel holds its old value and sel_valid=0. The next edge loads the new sel with sel_valid=1 and step=1. Period per index becomes dwell+2. No BLANK occurs after the final index of a single sweep; done timing is unchanged. stop in BLANK returns to IDLE.
- Undefined: no BLANK state; sel_valid stays 1 throughout RUN.

Test Plan:
1. Reset: rst_n=0 for 2 cycles with start=1 -> sel=0, sel_valid=0, busy=0, step=0, done=0. Release with start=0 -> remains IDLE.
2. Single sweep: dwell=2, last=3, single=1, start pulse -> sel sequence 0,0,0,1,1,1,2,2,2,3,3,3. Step pulses on the first cycle of 1, 2 and 3. The next cycle has done=1, busy=0, sel_valid=0. Total busy = 12 cycles.
3. Continuous wrap: dwell=0, last=7, single=0 -> sel 0..7,0,1 on consecutive cycles, step=1 every cycle after the first, done never asserted.
4. Stop mid-scan: dwell=3, last=5; assert stop when sel=2 -> the next cycle has sel=0, sel_valid=0, busy=0, done=0. A start and stop asserted together in IDLE leave busy=0.
5. Input latching and restart: change last from 3 to 1 during RUN -> sweep still ends at 3. A start in the done cycle -> busy=1, sel=0 on the following edge.
6. SCAN_BLANK_EN defined: dwell=1, last=2, single=1 -> sel_valid pattern 1,1,0,1,1,0,1,1, then done. sel shows 0,0,0,1,1,1,2,2. Step pulses on the first cycle of 1 and 2.
